// File: rtl/lsu_pkg.sv
// Load/store unit shared types, byte-enable constants and store formatting helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Byte enables for an access; halfwords ignore addr[0], words ignore addr[1:0].
    function automatic logic [3:0] lsu_byte_en(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            LSU_B, LSU_BU: return BE_BYTE << off;
            LSU_H, LSU_HU: return BE_HALF << {off[1], 1'b0};
            default:       return BE_WORD;
        endcase
    endfunction

    // Store data replicated across every lane so the byte enables pick the right copy.
    function automatic logic [31:0] lsu_store_data(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3)
            LSU_B, LSU_BU: return {4{wdata[7:0]}};
            LSU_H, LSU_HU: return {2{wdata[15:0]}};
            default:       return wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data lane select and sign/zero extension.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane and extend it according to the access type.
    always_comb begin
        shifted  = rdata >> {off, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LSU_B:   result = {{24{byte_sel[7]}}, byte_sel};
            LSU_BU:  result = {24'h0, byte_sel};
            LSU_H:   result = {{16{half_sel[15]}}, half_sel};
            LSU_HU:  result = {16'h0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: core execute-stage request to req/gnt/rvalid word memory.
// Build option MISALIGN_TRAP_EN: misaligned H/HU/W accesses complete with err and
// no memory access; otherwise low address bits are truncated.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_valid,
    input  logic              core_we,
    input  logic [2:0]        core_funct3,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic              core_busy,
    output logic              core_done,
    output logic [31:0]       core_rdata,
    output logic              core_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    lsu_state_e       state;
    logic [TMO_W-1:0] tmo_cnt;
    logic             lat_we;
    logic [2:0]       lat_funct3;
    logic [1:0]       lat_off;
    logic             legal;
    logic             misaligned;
    logic             access_ok;
    logic [31:0]      load_data;

    lsu_load_align u_load_align (
        .rdata  (mem_rdata),
        .funct3 (lat_funct3),
        .off    (lat_off),
        .result (load_data)
    );

    // Classify the incoming request: legal type/direction and, optionally, alignment.
    always_comb begin
        case (core_funct3)
            LSU_B, LSU_H, LSU_W: legal = 1'b1;
            LSU_BU, LSU_HU:      legal = !core_we;
            default:             legal = 1'b0;
        endcase
        misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if ((core_funct3 == LSU_H || core_funct3 == LSU_HU) && core_addr[0])
            misaligned = 1'b1;
        if (core_funct3 == LSU_W && core_addr[1:0] != 2'b00)
            misaligned = 1'b1;
`endif
        access_ok = legal && !misaligned;
    end

    // Stall while a request is being accepted or is outstanding; reset forces it low.
    always_comb begin
        core_busy = !rst && ((state == IDLE && core_valid) || state == REQ || state == WAIT);
    end

    // Access sequencing, timeout counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            lat_we     <= 1'b0;
            lat_funct3 <= '0;
            lat_off    <= '0;
            core_done  <= 1'b0;
            core_rdata <= '0;
            core_err   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
        end else begin
            core_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_valid) begin
                        lat_we     <= core_we;
                        lat_funct3 <= core_funct3;
                        lat_off    <= core_addr[1:0];
                        core_rdata <= '0;
                        if (access_ok) begin
                            state     <= REQ;
                            tmo_cnt   <= '0;
                            core_err  <= 1'b0;
                            mem_req   <= 1'b1;
                            mem_we    <= core_we;
                            mem_addr  <= core_addr[ADDR_W-1:2];
                            mem_be    <= lsu_byte_en(core_funct3, core_addr[1:0]);
                            mem_wdata <= lsu_store_data(core_funct3, core_wdata);
                        end else begin
                            state     <= DONE;
                            core_done <= 1'b1;
                            core_err  <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (lat_we) begin
                            state     <= DONE;
                            core_done <= 1'b1;
                        end else if (mem_rvalid) begin
                            state      <= DONE;
                            core_done  <= 1'b1;
                            core_rdata <= load_data;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state      <= DONE;
                        mem_req    <= 1'b0;
                        core_done  <= 1'b1;
                        core_err   <= 1'b1;
                        core_rdata <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state      <= DONE;
                        core_done  <= 1'b1;
                        core_rdata <= load_data;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state      <= DONE;
                        core_done  <= 1'b1;
                        core_err   <= 1'b1;
                        core_rdata <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    core_err   <= 1'b0;
                    core_rdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT_CYC=8).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_valid;
    logic        core_we;
    logic [2:0]  core_funct3;
    logic [15:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_busy;
    logic        core_done;
    logic [31:0] core_rdata;
    logic        core_err;
    logic        mem_req;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    load_store_unit #(.ADDR_W(16), .TIMEOUT_CYC(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .core_valid  (core_valid),
        .core_we     (core_we),
        .core_funct3 (core_funct3),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_busy   (core_busy),
        .core_done   (core_done),
        .core_rdata  (core_rdata),
        .core_err    (core_err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(core_busy), 32'd0);
        chk({tag, "_done"}, 32'(core_done), 32'd0);
        chk({tag, "_rdata"}, core_rdata, 32'd0);
        chk({tag, "_err"}, 32'(core_err), 32'd0);
        chk({tag, "_req"}, 32'(mem_req), 32'd0);
    endtask

    task automatic present(input logic we, input logic [2:0] f3, input logic [15:0] addr,
                           input logic [31:0] wdata);
        core_valid  = 1'b1;
        core_we     = we;
        core_funct3 = f3;
        core_addr   = addr;
        core_wdata  = wdata;
    endtask

    task automatic finish_access();
        core_valid = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        tick();
    endtask

    // Load granted with rvalid in the same cycle: done two edges after valid.
    task automatic load_fast(input string tag, input logic [2:0] f3, input logic [15:0] addr,
                             input logic [31:0] word, input logic [3:0] exp_be,
                             input logic [31:0] exp_data);
        present(1'b0, f3, addr, 32'h0);
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        tick();
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_be"}, 32'(mem_be), 32'(exp_be));
        tick();
        chk({tag, "_done"}, 32'(core_done), 32'd1);
        chk({tag, "_rdata"}, core_rdata, exp_data);
        chk({tag, "_err"}, 32'(core_err), 32'd0);
        finish_access();
    endtask

    task automatic store_fast(input string tag, input logic [2:0] f3, input logic [15:0] addr,
                              input logic [31:0] wdata, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata);
        present(1'b1, f3, addr, wdata);
        mem_gnt = 1'b1;
        tick();
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_we"}, 32'(mem_we), 32'd1);
        chk({tag, "_be"}, 32'(mem_be), 32'(exp_be));
        chk({tag, "_wdata"}, mem_wdata, exp_wdata);
        tick();
        chk({tag, "_done"}, 32'(core_done), 32'd1);
        chk({tag, "_err"}, 32'(core_err), 32'd0);
        finish_access();
    endtask

    // Rejected request: done+err on the next edge with no memory request.
    task automatic reject(input string tag, input logic we, input logic [2:0] f3,
                          input logic [15:0] addr);
        present(we, f3, addr, 32'h0);
        tick();
        chk({tag, "_done"}, 32'(core_done), 32'd1);
        chk({tag, "_err"}, 32'(core_err), 32'd1);
        chk({tag, "_req"}, 32'(mem_req), 32'd0);
        finish_access();
        chk({tag, "_after_done"}, 32'(core_done), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        core_valid  = 1'b0;
        core_we     = 1'b0;
        core_funct3 = 3'b000;
        core_addr   = 16'h0;
        core_wdata  = 32'h0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
        tick();
        tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // 1: SW 0x0010, gnt in the first REQ cycle
        present(1'b1, 3'b010, 16'h0010, 32'hDEADBEEF);
        mem_gnt = 1'b1;
        #1;
        chk("sw_busy_idle", 32'(core_busy), 32'd1);
        tick();
        chk("sw_req", 32'(mem_req), 32'd1);
        chk("sw_we", 32'(mem_we), 32'd1);
        chk("sw_addr", 32'(mem_addr), 32'h004);
        chk("sw_be", 32'(mem_be), 32'hF);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_done_early", 32'(core_done), 32'd0);
        tick();
        chk("sw_done", 32'(core_done), 32'd1);
        chk("sw_err", 32'(core_err), 32'd0);
        chk("sw_req_drop", 32'(mem_req), 32'd0);
        finish_access();
        chk("sw_done_pulse", 32'(core_done), 32'd0);
        chk("sw_busy_end", 32'(core_busy), 32'd0);

        // 2: LB 0x0013, rvalid two cycles after gnt
        present(1'b0, 3'b000, 16'h0013, 32'h0);
        mem_gnt = 1'b1;
        tick();
        chk("lb_req", 32'(mem_req), 32'd1);
        chk("lb_we", 32'(mem_we), 32'd0);
        chk("lb_addr", 32'(mem_addr), 32'h004);
        chk("lb_be", 32'(mem_be), 32'h8);
        tick();
        mem_gnt = 1'b0;
        chk("lb_wait_req", 32'(mem_req), 32'd0);
        chk("lb_wait_busy", 32'(core_busy), 32'd1);
        chk("lb_wait_done", 32'(core_done), 32'd0);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80FF_0000;
        tick();
        chk("lb_done", 32'(core_done), 32'd1);
        chk("lb_rdata", core_rdata, 32'hFFFFFF80);
        chk("lb_err", 32'(core_err), 32'd0);
        finish_access();

        // 3: halfword / byte loads and stores
        load_fast("lhu", 3'b101, 16'h0012, 32'h8001_1234, 4'b1100, 32'h0000_8001);
        load_fast("lh_hi", 3'b001, 16'h0012, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
        load_fast("lh_lo", 3'b001, 16'h0010, 32'h8001_1234, 4'b0011, 32'h0000_1234);
        load_fast("lbu", 3'b100, 16'h0011, 32'h0000_F000, 4'b0010, 32'h0000_00F0);
        load_fast("lw", 3'b010, 16'h0014, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
        store_fast("sh", 3'b001, 16'h0012, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD);
        store_fast("sb", 3'b000, 16'h0011, 32'h1234_565A, 4'b0010, 32'h5A5A_5A5A);

        // Illegal funct3 and unsigned-type stores
        reject("ill_011", 1'b0, 3'b011, 16'h0010);
        reject("ill_111", 1'b0, 3'b111, 16'h0010);
        reject("sbu", 1'b1, 3'b100, 16'h0010);
        reject("shu", 1'b1, 3'b101, 16'h0010);

        // 4: LW 0x0011 misaligned
`ifdef MISALIGN_TRAP_EN
        reject("lw_mis", 1'b0, 3'b010, 16'h0011);
        reject("sh_mis", 1'b1, 3'b001, 16'h0013);
`else
        present(1'b0, 3'b010, 16'h0011, 32'h0);
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1122_3344;
        tick();
        chk("lw_mis_req", 32'(mem_req), 32'd1);
        chk("lw_mis_addr", 32'(mem_addr), 32'h004);
        chk("lw_mis_be", 32'(mem_be), 32'hF);
        tick();
        chk("lw_mis_done", 32'(core_done), 32'd1);
        chk("lw_mis_rdata", core_rdata, 32'h1122_3344);
        chk("lw_mis_err", 32'(core_err), 32'd0);
        finish_access();
        store_fast("sh_mis", 3'b001, 16'h0013, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
`endif

        // 5: timeout with mem_gnt held low
        present(1'b0, 3'b010, 16'h0020, 32'h0);
        tick();
        chk("tmo_req_entry", 32'(mem_req), 32'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("tmo_pending_done_%0d", i), 32'(core_done), 32'd0);
            chk($sformatf("tmo_pending_req_%0d", i), 32'(mem_req), 32'd1);
        end
        tick();
        chk("tmo_done", 32'(core_done), 32'd1);
        chk("tmo_err", 32'(core_err), 32'd1);
        chk("tmo_rdata", core_rdata, 32'd0);
        chk("tmo_req_drop", 32'(mem_req), 32'd0);
        finish_access();
        chk("tmo_req_after", 32'(mem_req), 32'd0);
        chk("tmo_err_after", 32'(core_err), 32'd0);

        // 6: reset during WAIT
        present(1'b0, 3'b010, 16'h0024, 32'h0);
        mem_gnt = 1'b1;
        tick();
        tick();
        mem_gnt = 1'b0;
        chk("rst_in_wait_busy", 32'(core_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk_idle_outputs("rst_async");
        tick();
        rst        = 1'b0;
        core_valid = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        tick();
        chk_idle_outputs("rst_stray_rvalid");
        mem_rvalid = 1'b0;
        tick();
        store_fast("post_rst_sw", 3'b010, 16'h0004, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
